// File: rtl/eeprom_word_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_seq_pkg
//  Description : Shared definitions for the EEPROM word sequencer: FSM state
//                encodings, controller op modes, ctrl/status bit positions
//                and a helper that assembles the controller ctrl word.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package eeprom_seq_pkg;

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LAUNCH  = 3'd1;
  localparam state_t S_RUN     = 3'd2;
  localparam state_t S_CLEAR   = 3'd3;
  localparam state_t S_WR_WAIT = 3'd4;
  localparam state_t S_RESP    = 3'd5;

  // Controller op mode values for ctrl[3:1]
  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;

  // Controller ctrl word bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 7;

  // Controller status word bit positions
  localparam int STAT_FIN      = 1;
  localparam int STAT_STATE_LO = 2;
  localparam int STAT_STATE_HI = 9;

  // Assemble the controller ctrl word; all unlisted bits are 0.
  function automatic logic [31:0] build_ctrl(input logic       en,
                                             input logic [2:0] op,
                                             input logic [2:0] rate,
                                             input logic       clr);
    logic [31:0] w;
    w           = '0;
    w[CTRL_EN]  = en;
    w[3:1]      = op;
    w[6:4]      = rate;
    w[CTRL_CLR] = clr;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eeprom_word_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single level signal coming from
//                the I2C controller's divided clock domain.
//  Ports       : i_clk  - destination clock
//                i_rst  - synchronous active-high reset (output clears to 0)
//                i_d    - asynchronous level input
//                o_q    - synchronised level
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/eeprom_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_word_sequencer
//  Description : Command stage in front of the I2C EEPROM controller. Turns a
//                32-bit word read/write request into a controller launch,
//                tracks completion via the status word, clears the finish
//                flag, waits out the EEPROM write cycle and returns a single
//                beat response (read data or timeout error).
//  Ports       : i_clk/i_rst              - clock, synchronous active-high reset
//                i_req_*/o_req_ready      - request channel (accepted in IDLE)
//                o_rsp_*                  - one-cycle response
//                o_busy                   - high whenever not idle
//                o_i2c_ctrl/dev/reg/w_data- controller command inputs
//                i_i2c_status/rd_data*    - controller status and read bytes
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_word_sequencer
  import eeprom_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [2:0]  CLK_RATE       = 3'd6,
  parameter int unsigned WR_WAIT_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [13:0] i_req_waddr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic [31:0] o_i2c_ctrl,
  output logic [6:0]  o_i2c_dev_addr,
  output logic [15:0] o_i2c_reg_addr,
  output logic [31:0] o_i2c_w_data,
  input  logic [31:0] i_i2c_status,
  input  logic [7:0]  i_i2c_rd_data,
  input  logic [7:0]  i_i2c_rd_data_2,
  input  logic [7:0]  i_i2c_rd_data_3,
  input  logic [7:0]  i_i2c_rd_data_4
);

  localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WAIT_W = (WR_WAIT_CYCLES > 2) ? $clog2(WR_WAIT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WR_WAIT_CYCLES - 1);

  state_t            state_q,   state_d;
  logic              op_read_q, op_read_d;
  logic [13:0]       waddr_q,   waddr_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              en_q,      en_d;
  logic              clr_q,     clr_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;

  logic fin_s, run_s;
  logic tmo_active, tmo_hit;
  logic unused_status_bits;

  // Status comes from the controller's divided clock: resynchronise both
  // the finish flag and the "controller not idle" indication.
  sync_2ff u_sync_fin (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_i2c_status[STAT_FIN]),
    .o_q   (fin_s)
  );

  sync_2ff u_sync_run (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (|i_i2c_status[STAT_STATE_HI:STAT_STATE_LO]),
    .o_q   (run_s)
  );

  assign unused_status_bits = ^{i_i2c_status[31:STAT_STATE_HI+1], i_i2c_status[0]};

  assign tmo_active = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_CLEAR);
  assign tmo_hit    = tmo_active && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    op_read_d = op_read_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    en_d      = en_q;
    clr_d     = clr_q;
    tmo_d     = tmo_q;
    wait_d    = wait_q;

    // Saturating timeout counter; it never reaches past TMO_LAST because
    // hitting it forces the FSM out of the counted states.
    if (tmo_active && (tmo_q != TMO_LAST)) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          op_read_d = ~i_req_write;
          waddr_d   = i_req_waddr;
          wdata_d   = i_req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          en_d      = 1'b1;
          clr_d     = 1'b0;
          tmo_d     = '0;
          state_d   = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        // The controller latches enable itself; dropping it once it is
        // running prevents a second transfer after it returns to idle.
        if (run_s) begin
          en_d    = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // A read makes two controller passes with a short idle gap between
        // them, so only the finish flag ends this state.
        if (fin_s) begin
          if (op_read_q) begin
            rdata_d = {i_i2c_rd_data, i_i2c_rd_data_2, i_i2c_rd_data_3, i_i2c_rd_data_4};
          end
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (!fin_s) begin
          clr_d = 1'b0;
          if (op_read_q || (WR_WAIT_CYCLES == 0)) begin
            state_d = S_RESP;
          end else begin
            wait_d  = '0;
            state_d = S_WR_WAIT;
          end
        end
      end

      S_WR_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_RESP: begin
        clr_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        en_d    = 1'b0;
        clr_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Timeout overrides whatever the counted state decided. The finish
    // clear is pulsed during the response cycle in case finish is late.
    if (tmo_hit) begin
      err_d   = 1'b1;
      en_d    = 1'b0;
      clr_d   = 1'b1;
      rdata_d = '0;
      state_d = S_RESP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      op_read_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      tmo_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_read_q <= op_read_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      en_q      <= en_d;
      clr_q     <= clr_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
    end
  end

  assign o_req_ready    = (state_q == S_IDLE);
  assign o_busy         = (state_q != S_IDLE);
  assign o_rsp_valid    = (state_q == S_RESP);
  assign o_rsp_rdata    = rdata_q;
  assign o_rsp_err      = err_q;
  assign o_i2c_ctrl     = build_ctrl(en_q, op_read_q ? OP_READ : OP_WRITE, CLK_RATE, clr_q);
  assign o_i2c_dev_addr = DEV_ADDR;
  assign o_i2c_reg_addr = {waddr_q, 2'b00};
  assign o_i2c_w_data   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eeprom_word_sequencer
//  Description : Directed bench for eeprom_word_sequencer. Instance "dut" is
//                driven by a behavioural I2C controller + EEPROM model;
//                instance "dut_nw" (no write wait) has its status driven
//                directly by the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_word_sequencer;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance with controller model ----------------
  logic        a_valid, a_write;
  logic [13:0] a_waddr;
  logic [31:0] a_wdata;
  logic        a_ready, a_rsp_valid, a_err, a_busy;
  logic [31:0] a_rdata, a_ctrl, a_w_data, a_status;
  logic [6:0]  a_dev;
  logic [15:0] a_reg;
  logic [7:0]  a_rd1, a_rd2, a_rd3, a_rd4;

  eeprom_word_sequencer #(
    .DEV_ADDR       (7'h50),
    .CLK_RATE       (3'd6),
    .WR_WAIT_CYCLES (40),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (a_valid),
    .i_req_write     (a_write),
    .i_req_waddr     (a_waddr),
    .i_req_wdata     (a_wdata),
    .o_req_ready     (a_ready),
    .o_rsp_valid     (a_rsp_valid),
    .o_rsp_rdata     (a_rdata),
    .o_rsp_err       (a_err),
    .o_busy          (a_busy),
    .o_i2c_ctrl      (a_ctrl),
    .o_i2c_dev_addr  (a_dev),
    .o_i2c_reg_addr  (a_reg),
    .o_i2c_w_data    (a_w_data),
    .i_i2c_status    (a_status),
    .i_i2c_rd_data   (a_rd1),
    .i_i2c_rd_data_2 (a_rd2),
    .i_i2c_rd_data_3 (a_rd3),
    .i_i2c_rd_data_4 (a_rd4)
  );

  // ---------------- instance with no write wait ----------------
  logic        b_valid, b_write;
  logic [13:0] b_waddr;
  logic [31:0] b_wdata;
  logic        b_ready, b_rsp_valid, b_err, b_busy;
  logic [31:0] b_rdata, b_ctrl, b_w_data, b_status;
  logic [6:0]  b_dev;
  logic [15:0] b_reg;

  eeprom_word_sequencer #(
    .DEV_ADDR       (7'h50),
    .CLK_RATE       (3'd6),
    .WR_WAIT_CYCLES (0),
    .TIMEOUT_CYCLES (1000)
  ) dut_nw (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (b_valid),
    .i_req_write     (b_write),
    .i_req_waddr     (b_waddr),
    .i_req_wdata     (b_wdata),
    .o_req_ready     (b_ready),
    .o_rsp_valid     (b_rsp_valid),
    .o_rsp_rdata     (b_rdata),
    .o_rsp_err       (b_err),
    .o_busy          (b_busy),
    .o_i2c_ctrl      (b_ctrl),
    .o_i2c_dev_addr  (b_dev),
    .o_i2c_reg_addr  (b_reg),
    .o_i2c_w_data    (b_w_data),
    .i_i2c_status    (b_status),
    .i_i2c_rd_data   (8'h00),
    .i_i2c_rd_data_2 (8'h00),
    .i_i2c_rd_data_3 (8'h00),
    .i_i2c_rd_data_4 (8'h00)
  );

  // ---------------- controller + EEPROM model ----------------
  // Triggered by a rising enable. Write: one 20-cycle pass. Read: address
  // pass, 3-cycle idle gap, data pass. NACK: one pass, then idle, no finish.
  bit          nack = 1'b0;
  int          m_phase = 0;
  int          m_cnt = 0;
  logic        m_is_read = 1'b0;
  logic        m_en_prev = 1'b0;
  logic        m_fin = 1'b0;
  logic [7:0]  m_state = 8'd0;
  int          m_fin_cyc = 0;
  logic        m_en_mid = 1'b1;
  logic [31:0] mem [int];

  assign a_status = {22'b0, m_state, m_fin, 1'b0};

  always @(posedge clk) begin
    m_en_prev <= a_ctrl[0];
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_fin   <= 1'b0;
      m_state <= 8'd0;
      a_rd1 <= 8'h00; a_rd2 <= 8'h00; a_rd3 <= 8'h00; a_rd4 <= 8'h00;
    end else begin
      if (m_fin && a_ctrl[7]) m_fin <= 1'b0;
      if (m_phase == 1 && m_cnt == 10) m_en_mid <= a_ctrl[0];
      case (m_phase)
        0: if (a_ctrl[0] && !m_en_prev) begin
             m_is_read <= (a_ctrl[3:1] == 3'd1);
             m_phase   <= 1;
             m_cnt     <= 0;
             m_state   <= 8'd1;
           end
        1: if (m_cnt == 19) begin
             m_cnt <= 0;
             if (nack) begin
               m_phase <= 0; m_state <= 8'd0;
             end else if (m_is_read) begin
               m_phase <= 2; m_state <= 8'd0;
             end else begin
               mem[int'(a_reg[15:2])] = a_w_data;
               m_phase <= 0; m_state <= 8'd0; m_fin <= 1'b1; m_fin_cyc <= cyc;
             end
           end else m_cnt <= m_cnt + 1;
        2: if (m_cnt == 2) begin
             m_cnt <= 0; m_phase <= 3; m_state <= 8'd2;
           end else m_cnt <= m_cnt + 1;
        3: if (m_cnt == 19) begin
             m_cnt <= 0; m_phase <= 0; m_state <= 8'd0; m_fin <= 1'b1; m_fin_cyc <= cyc;
             a_rd1 <= mem[int'(a_reg[15:2])][31:24];
             a_rd2 <= mem[int'(a_reg[15:2])][23:16];
             a_rd3 <= mem[int'(a_reg[15:2])][15:8];
             a_rd4 <= mem[int'(a_reg[15:2])][7:0];
           end else m_cnt <= m_cnt + 1;
        default: m_phase <= 0;
      endcase
    end
  end

  // Cumulative rising-edge counters for enable and finish-clear
  int   en_rises = 0;
  int   clr_rises = 0;
  logic mon_en_prev = 1'b0;
  logic mon_clr_prev = 1'b0;
  always @(posedge clk) begin
    mon_en_prev  <= a_ctrl[0];
    mon_clr_prev <= a_ctrl[7];
    if (a_ctrl[0] && !mon_en_prev)  en_rises  <= en_rises + 1;
    if (a_ctrl[7] && !mon_clr_prev) clr_rises <= clr_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp_a(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (a_rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  bit   got;
  int   base_en, base_clr, c0, diff, nrsp;
  logic prev_clr;
  logic [31:0] seen_reg, seen_wd;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_waddr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_waddr = '0; b_wdata = '0;
    b_status = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- reset state ----
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_busy",  32'(a_busy), 32'd0);
    check("rst_ctrl",  a_ctrl, 32'h60);
    check("rst_rsp",   32'(a_rsp_valid), 32'd0);
    check("rst_reg",   32'(a_reg), 32'd0);
    check("rst_wdata", a_w_data, 32'd0);
    check("rst_dev",   32'(a_dev), 32'h50);

    // ---- write 0xDEADBEEF to word 0x0010 ----
    a_valid = 1'b1; a_write = 1'b1; a_waddr = 14'h0010; a_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("wr_ready_low", 32'(a_ready), 32'd0);
    check("wr_ctrl_launch", a_ctrl, 32'h61);
    seen_reg = 32'hFFFF_FFFF; seen_wd = 32'h0;
    wait (m_phase == 1);
    #1;
    seen_reg = 32'(a_reg); seen_wd = a_w_data;
    check("wr_reg_addr", seen_reg, 32'h0040);
    check("wr_w_data", seen_wd, 32'hDEADBEEF);
    wait_rsp_a(2000, got);
    check("wr_rsp_seen", 32'(got), 32'd1);
    check("wr_en_dropped", 32'(m_en_mid), 32'd0);
    diff = cyc - m_fin_cyc;
    check("wr_wait_min", 32'(diff >= 40), 32'd1);
    check("wr_wait_max", 32'(diff <= 60), 32'd1);
    check("wr_err", 32'(a_err), 32'd0);
    check("wr_mem", mem[16], 32'hDEADBEEF);
    @(posedge clk); #1;
    check("wr_rsp_one_cycle", 32'(a_rsp_valid), 32'd0);

    // ---- read word 0x0010 ----
    base_clr = clr_rises;
    a_valid = 1'b1; a_write = 1'b0; a_waddr = 14'h0010;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("rd_ctrl_launch", a_ctrl, 32'h63);
    wait_rsp_a(2000, got);
    check("rd_rsp_seen", 32'(got), 32'd1);
    check("rd_data", a_rdata, 32'hDEADBEEF);
    check("rd_err", 32'(a_err), 32'd0);
    check("rd_clr_pulses", 32'(clr_rises - base_clr), 32'd1);
    check("rd_fin_cleared", 32'(m_fin), 32'd0);

    // ---- back-to-back: valid held during busy ----
    @(posedge clk); #1;
    base_en = en_rises;
    a_valid = 1'b1; a_write = 1'b0; a_waddr = 14'h0010;
    @(posedge clk); #1;
    wait_rsp_a(2000, got);
    check("b2b_rsp1_seen", 32'(got), 32'd1);
    check("b2b_launches_1", 32'(en_rises - base_en), 32'd1);
    @(posedge clk); #1;
    check("b2b_ready_back", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("b2b_reaccepted", 32'(a_busy), 32'd1);
    wait_rsp_a(2000, got);
    check("b2b_rsp2_seen", 32'(got), 32'd1);
    check("b2b_data2", a_rdata, 32'hDEADBEEF);
    check("b2b_launches_2", 32'(en_rises - base_en), 32'd2);

    // ---- NACK -> timeout after 1000 cycles ----
    @(posedge clk); #1;
    nack = 1'b1;
    a_valid = 1'b1; a_write = 1'b0; a_waddr = 14'h0020;
    @(posedge clk); #1;
    a_valid = 1'b0;
    c0 = cyc;
    wait_rsp_a(1100, got);
    check("to_rsp_seen", 32'(got), 32'd1);
    check("to_latency", 32'(cyc - c0), 32'd1000);
    check("to_err", 32'(a_err), 32'd1);
    check("to_rdata", a_rdata, 32'd0);
    check("to_ctrl_resp", a_ctrl, 32'hE2);
    @(posedge clk); #1;
    check("to_idle_busy", 32'(a_busy), 32'd0);
    check("to_idle_ready", 32'(a_ready), 32'd1);
    check("to_clr_dropped", 32'(a_ctrl[7]), 32'd0);
    nack = 1'b0;

    // ---- reset during S_RUN of a read ----
    a_valid = 1'b1; a_write = 1'b0; a_waddr = 14'h0010;
    @(posedge clk); #1;
    a_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_phase == 3) begin
        got = 1'b1;
        break;
      end
    end
    check("mr_reached_run", 32'(got), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_busy", 32'(a_busy), 32'd0);
    check("mr_ready", 32'(a_ready), 32'd1);
    check("mr_ctrl", a_ctrl, 32'h60);
    check("mr_rsp", 32'(a_rsp_valid), 32'd0);
    nrsp = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (a_rsp_valid) nrsp++;
    end
    check("mr_no_late_rsp", 32'(nrsp), 32'd0);

    // ---- zero write-wait instance ----
    b_valid = 1'b1; b_write = 1'b1; b_waddr = 14'h0005; b_wdata = 32'h12345678;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("nw_busy", 32'(b_busy), 32'd1);
    check("nw_reg_addr", 32'(b_reg), 32'h0014);
    b_status = 32'h0000_0004;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!b_ctrl[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("nw_en_drop", 32'(got), 32'd1);
    b_status = 32'h0000_0002;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_ctrl[7]) begin
        got = 1'b1;
        break;
      end
    end
    check("nw_clr_seen", 32'(got), 32'd1);
    b_status = 32'h0;
    prev_clr = b_ctrl[7];
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_rsp_valid) begin
        got = 1'b1;
        break;
      end
      prev_clr = b_ctrl[7];
    end
    check("nw_rsp_seen", 32'(got), 32'd1);
    check("nw_clr_prev_cycle", 32'(prev_clr), 32'd1);
    check("nw_err", 32'(b_err), 32'd0);
    check("nw_rdata", b_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
